// File: rtl/hack_control_unit_if.sv
// rtl/hack_control_unit_if.sv - fetch, data-memory and ALU signal bundle for the Hack control unit
interface hack_control_unit_if;
  // instruction ROM handshake
  logic        instr_req;
  logic [14:0] pc;
  logic        instr_valid;
  logic [15:0] instr;
  // data RAM handshake
  logic [14:0] dmem_addr;
  logic        dmem_re;
  logic        dmem_we;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;
  // ALU operands, control bits and results
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  // register observation
  logic [15:0] a_reg;
  logic [15:0] d_reg;

  // control unit side
  modport master (
    output instr_req, pc, dmem_addr, dmem_re, dmem_we, dmem_wdata,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output a_reg, d_reg,
    input  instr_valid, instr, dmem_rdata, dmem_ready, alu_out, alu_zr, alu_ng
  );

  // memories and ALU side
  modport slave (
    input  instr_req, pc, dmem_addr, dmem_re, dmem_we, dmem_wdata,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  a_reg, d_reg,
    output instr_valid, instr, dmem_rdata, dmem_ready, alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_control_unit.sv
// rtl/hack_control_unit.sv - multi-cycle fetch/decode/execute sequencer for a Hack-style datapath
module hack_control_unit #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hack_control_unit_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MEMRD = 2'd1,
    EXEC  = 2'd2,
    MEMWR = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [14:0] pc_q;
  logic [15:0] a_q;
  logic [15:0] d_q;
  logic [15:0] ir_q;
  logic [15:0] m_q;
  logic [15:0] wdata_q;
  logic [14:0] wr_addr_q;
  logic        jump_taken;
  logic [14:0] pc_inc;

  // 15-bit increment wraps naturally from 0x7FFF to 0x0000
  assign pc_inc = pc_q + 15'd1;

  // jump condition from the ALU flags sampled during EXEC
  assign jump_taken = (ir_q[2] & bus.alu_ng)
                    | (ir_q[1] & bus.alu_zr)
                    | (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic: each state waits on its own handshake
  always_comb begin
    state_nx = state;
    case (state)
      FETCH: begin
        if (bus.instr_valid) begin
          state_nx = (bus.instr[15] && bus.instr[12]) ? MEMRD : EXEC;
        end
      end
      MEMRD: begin
        if (bus.dmem_ready) begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        state_nx = (ir_q[15] && ir_q[3]) ? MEMWR : FETCH;
      end
      MEMWR: begin
        if (bus.dmem_ready) begin
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // request strobes, gated by reset so an aborted handshake drops immediately
  always_comb begin
    bus.instr_req = 1'b0;
    bus.dmem_re   = 1'b0;
    bus.dmem_we   = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH:   bus.instr_req = 1'b1;
        MEMRD:   bus.dmem_re   = 1'b1;
        MEMWR:   bus.dmem_we   = 1'b1;
        default: ;
      endcase
    end
  end

  // the write address is the A value captured before the instruction updated A
  assign bus.dmem_addr  = (state == MEMWR) ? wr_addr_q : a_q[14:0];
  assign bus.dmem_wdata = wdata_q;
  assign bus.pc         = pc_q;

  // ALU operands and control bits follow IR in every state
  assign bus.alu_x  = d_q;
  assign bus.alu_y  = ir_q[12] ? m_q : a_q;
  assign bus.alu_zx = ir_q[11];
  assign bus.alu_nx = ir_q[10];
  assign bus.alu_zy = ir_q[9];
  assign bus.alu_ny = ir_q[8];
  assign bus.alu_f  = ir_q[7];
  assign bus.alu_no = ir_q[6];

  assign bus.a_reg = a_q;
  assign bus.d_reg = d_q;

  // datapath registers: capture IR and M, then retire the instruction in EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      a_q       <= 16'h0000;
      d_q       <= 16'h0000;
      ir_q      <= 16'h0000;
      m_q       <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_addr_q <= 15'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir_q <= bus.instr;
          end
        end
        MEMRD: begin
          if (bus.dmem_ready) begin
            m_q <= bus.dmem_rdata;
          end
        end
        EXEC: begin
          if (!ir_q[15]) begin
            a_q  <= {1'b0, ir_q[14:0]};
            pc_q <= pc_inc;
          end else begin
            if (ir_q[5]) begin
              a_q <= bus.alu_out;
            end
            if (ir_q[4]) begin
              d_q <= bus.alu_out;
            end
            if (ir_q[3]) begin
              wdata_q   <= bus.alu_out;
              wr_addr_q <= a_q[14:0];
            end
            pc_q <= jump_taken ? a_q[14:0] : pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
